// File: rtl/nice_pkg.sv
// Shared types and constants for the QPD position-sample frame FIFO.
// A frame is one sequence word followed by NUM_CH sign-extended samples.
package nice_pkg;
  localparam int DATA_BITS   = 24;
  localparam int NUM_CH      = 4;
  localparam int FRAME_WORDS = NUM_CH + 1;
  localparam int WORD_BITS   = 32;

  typedef logic signed [23:0] sample_t;
  typedef logic [31:0]        word_t;

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  function automatic word_t sext_sample(input sample_t s);
    return {{($bits(word_t) - $bits(sample_t)){s[$bits(sample_t)-1]}}, s};
  endfunction
endpackage

// File: rtl/pos_sample_fifo_frame_fifo.sv
// Generic whole-entry FIFO: one push stores a full frame, one pop retires it.
// Full/empty are derived from the level counter, so pointers wrap freely.
module frame_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LW-1:0]    level_o,
  output logic             accept_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;

  assign w_pop = pop_i && (r_level != '0);
  // A full FIFO still takes a push when the head retires in the same cycle.
  assign accept_o = push_i && !flush_i && ((r_level != LW'(DEPTH)) || w_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (accept_o) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(accept_o) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_o) r_mem[r_wr_ptr] <= wr_data_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;
endmodule

// File: rtl/pos_sample_fifo.sv
// Captures {seq, x1, i1, x2, i2} per demod tick into a frame FIFO and streams
// the head frame out one 32-bit word at a time; refused frames are counted.
module pos_sample_fifo
  import nice_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        tick_i,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_i,
  input  logic                        flush_i,
  input  logic                        rd_ready_i,
  output logic                        rd_valid_o,
  output logic [31:0]                 rd_data_o,
  output logic                        rd_last_o,
  output logic [LW-1:0]               level_o,
  output logic [31:0]                 drop_count_o
);
  localparam int FW = NUM_CH * DATA_BITS + WORD_BITS;
  localparam int IW = $clog2(FRAME_WORDS);

  word_t           r_seq;
  word_t           r_drop;
  logic [IW-1:0]   r_idx;
  rd_state_t       r_state;

  logic [FW-1:0]   w_frame_in;
  logic [FW-1:0]   w_head;
  logic [LW-1:0]   w_level;
  logic            w_accept;
  logic            w_valid;
  logic            w_pop;
  logic            w_last_word;
  logic            w_frame_pop;
  word_t           w_words [FRAME_WORDS];

  assign w_frame_in  = {ch_i, r_seq};
  assign w_valid     = (r_state == RD_STREAM);
  assign w_pop       = w_valid && rd_ready_i;
  assign w_last_word = (r_idx == IW'(NUM_CH));
  assign w_frame_pop = w_pop && w_last_word;

  frame_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .push_i    (tick_i),
    .pop_i     (w_frame_pop),
    .wr_data_i (w_frame_in),
    .head_o    (w_head),
    .level_o   (w_level),
    .accept_o  (w_accept)
  );

  assign w_words[0] = w_head[WORD_BITS-1:0];
  for (genvar gi = 1; gi < FRAME_WORDS; gi++) begin : g_word
    assign w_words[gi] = sext_sample(sample_t'(w_head[WORD_BITS + (gi-1)*DATA_BITS +: DATA_BITS]));
  end

  // A tick coinciding with flush is discarded entirely: no seq step, no drop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_seq  <= '0;
      r_drop <= '0;
    end else begin
      if (tick_i && !flush_i) r_seq <= r_seq + 1'b1;
      if (flush_i)
        r_drop <= '0;
      else if (tick_i && !w_accept && (r_drop != '1))
        r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= RD_IDLE;
      r_idx   <= '0;
    end else if (flush_i) begin
      r_state <= RD_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (w_accept) r_state <= RD_STREAM;
        end
        RD_STREAM: begin
          if (w_pop) r_idx <= w_last_word ? '0 : r_idx + 1'b1;
          if (w_frame_pop && (w_level == LW'(1)) && !w_accept) r_state <= RD_IDLE;
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign rd_valid_o   = w_valid;
  assign rd_data_o    = w_valid ? w_words[r_idx] : '0;
  assign rd_last_o    = w_valid && w_last_word;
  assign level_o      = w_level;
  assign drop_count_o = r_drop;
endmodule

// File: tb/tb_pos_sample_fifo.sv
// Bench for pos_sample_fifo: fixed vector table, directed corner sequences and
// a random run checked against a queue-of-frames reference model.
module tb_pos_sample_fifo;
  import nice_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        tick = 1'b0;
  logic                        flush = 1'b0;
  logic                        rdy = 1'b0;
  logic [NUM_CH*DATA_BITS-1:0] ch = '0;
  logic                        rd_valid;
  logic                        rd_last;
  logic [31:0]                 rd_data;
  logic [31:0]                 drop;
  logic [LW-1:0]               level;

  always #5 clk = ~clk;

  pos_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .tick_i       (tick),
    .ch_i         (ch),
    .flush_i      (flush),
    .rd_ready_i   (rdy),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .rd_last_o    (rd_last),
    .level_o      (level),
    .drop_count_o (drop)
  );

  // Reference model: a queue of whole frames plus a read cursor.
  typedef logic [FRAME_WORDS-1:0][31:0] frame_t;
  frame_t      mq[$];
  int          m_idx;
  logic [31:0] m_seq;
  logic [31:0] m_drop;
  frame_t      cur_frame;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        tick;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    int          exp_level;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_ch_vals(input int v0, input int v1, input int v2, input int v3);
    int v[NUM_CH];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int k = 0; k < NUM_CH; k++) begin
      ch[k*DATA_BITS +: DATA_BITS] = v[k][DATA_BITS-1:0];
      cur_frame[k+1] = v[k];
    end
  endtask

  task automatic set_ch_random();
    int v[NUM_CH];
    for (int k = 0; k < NUM_CH; k++)
      v[k] = int'($urandom_range(0, 32'hFF_FFFF)) - 32'h80_0000;
    set_ch_vals(v[0], v[1], v[2], v[3]);
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    m_seq  = '0;
    m_drop = '0;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, mq.size() != 0});
    chk({tag, "_level"}, 32'(level), mq.size());
    chk({tag, "_drop"}, drop, m_drop);
    if (mq.size() != 0) begin
      chk({tag, "_data"}, rd_data, mq[0][m_idx]);
      chk({tag, "_last"}, {31'd0, rd_last}, {31'd0, m_idx == NUM_CH});
    end
  endtask

  // Next-state of the model from the inputs currently being driven.
  task automatic model_update();
    bit     frame_done;
    int     sz;
    frame_t f;
    frame_done = 1'b0;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      m_idx  = 0;
      m_drop = '0;
    end else begin
      if (sz != 0 && rdy) begin
        if (m_idx == NUM_CH) begin
          frame_done = 1'b1;
          m_idx = 0;
          void'(mq.pop_front());
        end else begin
          m_idx++;
        end
      end
      if (tick) begin
        if (sz < DEPTH || frame_done) begin
          f = cur_frame;
          f[0] = m_seq;
          mq.push_back(f);
        end else if (m_drop != 32'hFFFF_FFFF) begin
          m_drop++;
        end
        m_seq++;
      end
    end
  endtask

  task automatic cyc_begin(input logic t, input logic f, input logic r);
    tick = t; flush = f; rdy = r;
    @(negedge clk);
  endtask

  task automatic cyc_end();
    model_update();
    @(posedge clk);
    #1;
    tick = 1'b0; flush = 1'b0;
  endtask

  task automatic cyc(input logic t, input logic f, input logic r, input string tag);
    cyc_begin(t, f, r);
    model_check(tag);
    cyc_end();
  endtask

  task automatic do_reset();
    tick = 1'b0; flush = 1'b0; rdy = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop", drop, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vt[0] = '{tick:1'b1, rdy:1'b0, exp_valid:1'b0, exp_data:32'h0,        exp_last:1'b0, exp_level:0};
    vt[1] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b1, exp_data:32'h00000000, exp_last:1'b0, exp_level:1};
    vt[2] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b1, exp_data:32'hFFFFFFFF, exp_last:1'b0, exp_level:1};
    vt[3] = '{tick:1'b0, rdy:1'b0, exp_valid:1'b1, exp_data:32'h00000002, exp_last:1'b0, exp_level:1};
    vt[4] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b1, exp_data:32'h00000002, exp_last:1'b0, exp_level:1};
    vt[5] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b1, exp_data:32'hFFFFFFFD, exp_last:1'b0, exp_level:1};
    vt[6] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b1, exp_data:32'h00000004, exp_last:1'b1, exp_level:1};
    vt[7] = '{tick:1'b0, rdy:1'b1, exp_valid:1'b0, exp_data:32'h0,        exp_last:1'b0, exp_level:0};

    // Reset and single frame {-1,2,-3,4}, with one stalled word.
    do_reset();
    set_ch_vals(-1, 2, -3, 4);
    for (int i = 0; i < 8; i++) begin
      cyc_begin(vt[i].tick, 1'b0, vt[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].exp_valid});
      chk($sformatf("vec%0d_level", i), 32'(level), vt[i].exp_level);
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), rd_data, vt[i].exp_data);
        chk($sformatf("vec%0d_last", i), {31'd0, rd_last}, {31'd0, vt[i].exp_last});
      end
      cyc_end();
    end

    // Overflow: 20 ticks, nothing read.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_ch_random();
      cyc(1'b1, 1'b0, 1'b0, "ovf_fill");
    end
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_drop", drop, 32'd4);
    cyc_end();
    for (int f = 0; f < 16; f++) begin
      for (int w = 0; w < FRAME_WORDS; w++) begin
        cyc_begin(1'b0, 1'b0, 1'b1);
        model_check("ovf_drain");
        if (w == 0) chk("ovf_seq", rd_data, f);
        cyc_end();
      end
    end
    set_ch_random();
    cyc(1'b1, 1'b0, 1'b0, "ovf_push");
    cyc_begin(1'b0, 1'b0, 1'b1);
    chk("ovf_next_seq", rd_data, 32'd20);
    cyc_end();
    cyc(1'b0, 1'b0, 1'b1, "mid_pop");

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_data", rd_data, 32'd0);
    chk("async_last", {31'd0, rd_last}, 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_drop", drop, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc_begin(1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", {31'd0, rd_valid}, 32'd0);
    cyc_end();

    // Push coinciding with the last-word pop while full.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_ch_random();
      cyc(1'b1, 1'b0, 1'b0, "full_fill");
    end
    for (int i = 0; i < NUM_CH; i++) cyc(1'b0, 1'b0, 1'b1, "full_pop");
    set_ch_random();
    cyc_begin(1'b1, 1'b0, 1'b1);
    chk("full_last_now", {31'd0, rd_last}, 32'd1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_drop", drop, 32'd0);
    cyc_end();
    for (int f = 0; f < 16; f++) begin
      for (int w = 0; w < FRAME_WORDS; w++) begin
        cyc_begin(1'b0, 1'b0, 1'b1);
        model_check("full_drain");
        if (w == 0 && f == 15) chk("full_newest_last", rd_data, 32'd16);
        cyc_end();
      end
    end

    // Flush with a coincident tick at level 5.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_ch_random();
      cyc(1'b1, 1'b0, 1'b0, "fl_fill");
    end
    for (int i = 0; i < 11 * FRAME_WORDS; i++) cyc(1'b0, 1'b0, 1'b1, "fl_drain");
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("fl_pre_level", 32'(level), 32'd5);
    chk("fl_pre_drop", drop, 32'd2);
    cyc_end();
    set_ch_random();
    cyc(1'b1, 1'b1, 1'b1, "fl_cycle");
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_drop", drop, 32'd0);
    chk("fl_valid", {31'd0, rd_valid}, 32'd0);
    cyc_end();
    set_ch_random();
    cyc(1'b1, 1'b0, 1'b0, "fl_push");
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("fl_seq", rd_data, 32'd18);
    cyc_end();

    // Random run: 1000 ticks, varying drain pressure, occasional flush.
    begin
      int ticks = 0;
      int ncyc = 0;
      int pr = 50;
      logic t, f, r;
      while (ticks < 1000 && ncyc < 20000) begin
        if (ncyc % 200 == 0) pr = $urandom_range(15, 95);
        t = ($urandom_range(0, 2) == 0);
        f = ($urandom_range(0, 399) == 0);
        r = ($urandom_range(0, 99) < pr);
        if (t) begin
          set_ch_random();
          ticks++;
        end
        cyc(t, f, r, "rnd");
        ncyc++;
      end
      chk("rnd_ticks_done", ticks, 32'd1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
